layer_composer_n: RTL and testbench

Parametrised next-generation composer. Generates display timing counters, fractional X/Y scaling and line-render requests. Merges NUM_LAYERS tile/bitmap line buffers with one sprite line buffer using per-pixel sprite depth, then emits registered display pixels. Sits between the layer/sprite renderers and the video timing generator; the composition result is registered so the block can run at higher pixel clocks.

---
 rtl/layer_composer_pkg.sv | 23 ++
 rtl/composer_priority_mux.sv | 37 +++
 rtl/layer_composer_n.sv | 168 ++++++++++++++++
 tb/tb_layer_composer_n.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_composer_pkg.sv
// Shared widths and sprite-depth helpers for the layer composer.
package layer_composer_pkg;

    localparam int Z_HIDDEN      = 0;
    localparam int DEF_LAYERS    = 2;
    localparam int DEF_PIX_W     = 8;
    localparam int DEF_H_W       = 10;
    localparam int DEF_V_W       = 9;
    localparam int DEF_FRAC_W    = 7;
    localparam int DEF_LINE_PIX  = 640;
    localparam int DEF_LINE_ROWS = 480;
    localparam int DEF_ZW        = 3;

    // Sprite depth z sits directly beneath layer z-1; z=N+1 is above all.
    function automatic logic sprite_in_slot(
        input int z,
        input int slot,
        input int num_layers
    );
        return (z != Z_HIDDEN) && (z <= num_layers + 1) && (z == slot + 1);
    endfunction

endpackage

// File: rtl/composer_priority_mux.sv
// Combinational merge of N layer pixels and one depth-tagged sprite pixel.
module composer_priority_mux
    import layer_composer_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_LAYERS,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int ZW         = DEF_ZW
) (
    input  logic [NUM_LAYERS-1:0]       layer_enable,
    input  logic                        sprites_enabled,
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_data,
    input  logic [PIX_W+ZW-1:0]         sprite_data,
    output logic [PIX_W-1:0]            pixel
);

    logic [ZW-1:0]    sprite_z;
    logic [PIX_W-1:0] sprite_pix;
    logic             sprite_on;

    assign sprite_z   = sprite_data[PIX_W +: ZW];
    assign sprite_pix = sprite_data[PIX_W-1:0];
    assign sprite_on  = sprites_enabled && (sprite_pix != '0);

    // Walk bottom to top; each opaque source overwrites what lies below.
    always_comb begin
        pixel = '0;
        for (int s = 0; s < NUM_LAYERS; s++) begin
            if (sprite_on && sprite_in_slot(int'(sprite_z), s, NUM_LAYERS))
                pixel = sprite_pix;
            if (layer_enable[s] && (layer_data[s*PIX_W +: PIX_W] != '0))
                pixel = layer_data[s*PIX_W +: PIX_W];
        end
        if (sprite_on && sprite_in_slot(int'(sprite_z), NUM_LAYERS, NUM_LAYERS))
            pixel = sprite_pix;
    end

endmodule

// File: rtl/layer_composer_n.sv
// Display counters, fractional X/Y scaling, render requests and a
// two-stage registered composition of layer and sprite line buffers.
module layer_composer_n
    import layer_composer_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_LAYERS,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int H_W        = DEF_H_W,
    parameter int V_W        = DEF_V_W,
    parameter int FRAC_W     = DEF_FRAC_W,
    parameter int LINE_PIX   = DEF_LINE_PIX,
    parameter int LINE_ROWS  = DEF_LINE_ROWS,
    parameter int ZW         = DEF_ZW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        interlaced,
    input  logic [7:0]                  frac_x_incr,
    input  logic [7:0]                  frac_y_incr,
    input  logic [PIX_W-1:0]            border_color,
    input  logic [H_W-1:0]              active_hstart,
    input  logic [H_W-1:0]              active_hstop,
    input  logic [V_W-1:0]              active_vstart,
    input  logic [V_W-1:0]              active_vstop,
    input  logic [V_W-1:0]              irqline,
    input  logic [NUM_LAYERS-1:0]       layer_enable,
    input  logic                        sprites_enabled,
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_lb_rddata,
    input  logic [PIX_W+ZW-1:0]         sprite_lb_rddata,
    input  logic                        display_next_frame,
    input  logic                        display_next_line,
    input  logic                        display_next_pixel,
    input  logic                        display_current_field,
    output logic                        current_field,
    output logic                        line_irq,
    output logic [V_W-1:0]              scanline,
    output logic [V_W-1:0]              line_idx,
    output logic                        line_render_start,
    output logic [H_W-1:0]              lb_rdidx,
    output logic                        sprite_lb_erase_start,
    output logic [PIX_W-1:0]            display_data,
    output logic                        display_valid
);

    localparam int SXW = H_W + FRAC_W;
    localparam int SYW = V_W + FRAC_W;

    logic [V_W:0]     y_ctr;
    logic [V_W:0]     y_prev;
    logic [H_W:0]     x_ctr;
    logic [H_W:0]     x_nxt;
    logic [H_W:0]     erase_at;
    logic [H_W-1:0]   x;
    logic [SXW-1:0]   scaled_x;
    logic [SYW-1:0]   scaled_y;
    logic [H_W-1:0]   sx_int;
    logic [V_W-1:0]   sy_int;
    logic [7:0]       x_step;
    logic [8:0]       y_step;
    logic             started;
    logic             line_pend;
    logic             hactive;
    logic             vactive;
    logic             irq_hit;
    logic             active_q;
    logic             strobe_q;
    logic [PIX_W-1:0] mux_pix;

    assign x        = x_ctr[H_W:1];
    assign x_nxt    = x_ctr + {{(H_W-1){1'b0}}, !interlaced, interlaced};
    assign erase_at = {H_W'(LINE_PIX - 1), interlaced};
    assign sx_int   = scaled_x[SXW-1:FRAC_W];
    assign sy_int   = scaled_y[SYW-1:FRAC_W];
    assign lb_rdidx = sx_int;
    assign line_idx = sy_int;
    assign scanline = y_prev[V_W] ? '1 : y_ctr[V_W-1:0];

    // Interlaced fields advance y by two lines, so x scales at half rate.
    assign x_step = interlaced ? {1'b0, frac_x_incr[7:1]} : frac_x_incr;
    assign y_step = interlaced ? {frac_y_incr, 1'b0} : {1'b0, frac_y_incr};

    assign hactive = (active_hstart <= x) && (x < active_hstop);
    assign vactive = ({1'b0, active_vstart} <= y_prev)
                  && (y_prev < {1'b0, active_vstop})
                  && (sy_int < V_W'(LINE_ROWS));

    assign irq_hit = interlaced
                   ? (y_ctr[V_W:1] == {1'b0, irqline[V_W-1:1]})
                   : (y_ctr == {1'b0, irqline});

    composer_priority_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .PIX_W      (PIX_W),
        .ZW         (ZW)
    ) u_mux (
        .layer_enable    (layer_enable),
        .sprites_enabled (sprites_enabled),
        .layer_data      (layer_lb_rddata),
        .sprite_data     (sprite_lb_rddata),
        .pixel           (mux_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            y_ctr                 <= '0;
            y_prev                <= '0;
            x_ctr                 <= '0;
            scaled_x              <= '0;
            scaled_y              <= '0;
            started               <= 1'b0;
            line_pend             <= 1'b0;
            current_field         <= 1'b0;
            line_irq              <= 1'b0;
            line_render_start     <= 1'b0;
            sprite_lb_erase_start <= 1'b0;
            active_q              <= 1'b0;
            strobe_q              <= 1'b0;
            display_valid         <= 1'b0;
            display_data          <= '0;
        end else begin
            line_irq              <= display_next_line && irq_hit;
            line_pend             <= display_next_line && !display_next_frame;
            line_render_start     <= 1'b0;
            sprite_lb_erase_start <= display_next_pixel && !display_next_line
                                  && (x_nxt == erase_at);

            if (display_next_frame) begin
                y_ctr         <= {{V_W{1'b0}}, interlaced && !display_current_field};
                current_field <= !display_current_field;
            end else if (display_next_line) begin
                y_ctr  <= y_ctr + {{(V_W-1){1'b0}}, interlaced, !interlaced};
                y_prev <= y_ctr;
            end

            if (display_next_line) begin
                x_ctr    <= '0;
                scaled_x <= '0;
            end else if (display_next_pixel) begin
                x_ctr <= x_nxt;
                if (hactive && (sx_int < H_W'(LINE_PIX)))
                    scaled_x <= scaled_x + SXW'(x_step);
            end

            // Y scaling settles one clock after the line strobe.
            if (line_pend) begin
                if (!started) begin
                    if (y_ctr >= {1'b0, active_vstart}) begin
                        started           <= 1'b1;
                        line_render_start <= 1'b1;
                        scaled_y          <= (interlaced && (current_field ^ active_vstart[0]))
                                           ? SYW'(frac_y_incr) : '0;
                    end
                end else if ((sy_int < V_W'(LINE_ROWS)) && vactive) begin
                    scaled_y          <= scaled_y + SYW'(y_step);
                    line_render_start <= 1'b1;
                end
            end
            if (display_next_frame)
                started <= 1'b0;

            active_q      <= hactive && vactive;
            strobe_q      <= display_next_pixel;
            display_valid <= strobe_q;
            display_data  <= active_q ? mux_pix : border_color;
        end
    end

endmodule

// File: tb/tb_layer_composer_n.sv
// Directed and randomized checks of layer_composer_n against a behavioural model.
module tb_layer_composer_n;

    localparam int NL = 4;
    localparam int PW = 8;
    localparam int HW = 10;
    localparam int VW = 9;
    localparam int ZW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic interlaced = 1'b0;
    logic [7:0] frac_x_incr = 8'd128;
    logic [7:0] frac_y_incr = 8'd128;
    logic [PW-1:0] border_color = 8'h1F;
    logic [HW-1:0] active_hstart = '0;
    logic [HW-1:0] active_hstop = 10'd640;
    logic [VW-1:0] active_vstart = '0;
    logic [VW-1:0] active_vstop = 9'd480;
    logic [VW-1:0] irqline = '0;
    logic [NL-1:0] layer_enable = '1;
    logic sprites_enabled = 1'b1;
    logic [NL*PW-1:0] layer_lb_rddata = '0;
    logic [PW+ZW-1:0] sprite_lb_rddata = '0;
    logic display_next_frame = 1'b0;
    logic display_next_line = 1'b0;
    logic display_next_pixel = 1'b0;
    logic display_current_field = 1'b0;
    logic current_field;
    logic line_irq;
    logic [VW-1:0] scanline;
    logic [VW-1:0] line_idx;
    logic line_render_start;
    logic [HW-1:0] lb_rdidx;
    logic sprite_lb_erase_start;
    logic [PW-1:0] display_data;
    logic display_valid;

    logic [NL-1:0] mx_en;
    logic mx_se;
    logic [NL*PW-1:0] mx_ld;
    logic [PW+ZW-1:0] mx_sd;
    logic [PW-1:0] mx_pix;

    int n_cmp = 0;
    int n_bad = 0;
    int m_y, m_yprev, m_sy, m_xc, m_sx;
    bit m_started, m_field;
    int irq_seen, erase_seen;

    always #5 clk = ~clk;

    layer_composer_n #(
        .NUM_LAYERS (NL),
        .ZW         (ZW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .interlaced            (interlaced),
        .frac_x_incr           (frac_x_incr),
        .frac_y_incr           (frac_y_incr),
        .border_color          (border_color),
        .active_hstart         (active_hstart),
        .active_hstop          (active_hstop),
        .active_vstart         (active_vstart),
        .active_vstop          (active_vstop),
        .irqline               (irqline),
        .layer_enable          (layer_enable),
        .sprites_enabled       (sprites_enabled),
        .layer_lb_rddata       (layer_lb_rddata),
        .sprite_lb_rddata      (sprite_lb_rddata),
        .display_next_frame    (display_next_frame),
        .display_next_line     (display_next_line),
        .display_next_pixel    (display_next_pixel),
        .display_current_field (display_current_field),
        .current_field         (current_field),
        .line_irq              (line_irq),
        .scanline              (scanline),
        .line_idx              (line_idx),
        .line_render_start     (line_render_start),
        .lb_rdidx              (lb_rdidx),
        .sprite_lb_erase_start (sprite_lb_erase_start),
        .display_data          (display_data),
        .display_valid         (display_valid)
    );

    composer_priority_mux #(
        .NUM_LAYERS (NL),
        .PIX_W      (PW),
        .ZW         (ZW)
    ) u_mux_solo (
        .layer_enable    (mx_en),
        .sprites_enabled (mx_se),
        .layer_data      (mx_ld),
        .sprite_data     (mx_sd),
        .pixel           (mx_pix)
    );

    // Top-down search: first opaque, enabled source from the top wins.
    function automatic logic [7:0] ref_pix(
        input logic [NL-1:0] en,
        input logic se,
        input logic [NL*PW-1:0] ld,
        input logic [PW+ZW-1:0] sd
    );
        int z;
        logic [7:0] sc;
        z = int'(sd[PW +: ZW]);
        sc = sd[PW-1:0];
        for (int i = NL; i >= 0; i--) begin
            if (se && z == i + 1 && sc != 0) return sc;
            if (i > 0 && en[i-1] && ld[(i-1)*PW +: PW] != 0)
                return ld[(i-1)*PW +: PW];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rnd_pix();
        if ($urandom_range(0, 2) == 0) return 8'h00;
        return 8'($urandom_range(1, 255));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_y = 0; m_yprev = 0; m_sy = 0; m_xc = 0; m_sx = 0;
        m_started = 0; m_field = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_field"}, current_field, 0);
        chk({tag, "_irq"}, line_irq, 0);
        chk({tag, "_scanline"}, scanline, 0);
        chk({tag, "_line_idx"}, line_idx, 0);
        chk({tag, "_render"}, line_render_start, 0);
        chk({tag, "_rdidx"}, lb_rdidx, 0);
        chk({tag, "_erase"}, sprite_lb_erase_start, 0);
        chk({tag, "_data"}, display_data, 0);
        chk({tag, "_valid"}, display_valid, 0);
    endtask

    task automatic do_line();
        int il;
        bit exp_irq, exp_rs;
        il = int'(interlaced);
        if (il != 0) exp_irq = (m_y >> 1) == (int'(irqline) >> 1);
        else         exp_irq = (m_y == int'(irqline));
        display_next_line = 1'b1;
        tick();
        display_next_line = 1'b0;
        m_yprev = m_y;
        m_y = m_y + ((il != 0) ? 2 : 1);
        m_xc = 0;
        m_sx = 0;
        if (line_irq === 1'b1) irq_seen++;
        chk("line_irq", line_irq, exp_irq);
        exp_rs = 0;
        if (!m_started) begin
            if (m_y >= int'(active_vstart)) begin
                m_started = 1;
                exp_rs = 1;
                m_sy = (il != 0 && (m_field ^ active_vstart[0])) ? int'(frac_y_incr) : 0;
            end
        end else if ((m_sy >> 7) < 480 && m_yprev >= int'(active_vstart)
                     && m_yprev < int'(active_vstop)) begin
            m_sy = m_sy + ((il != 0) ? 2 * int'(frac_y_incr) : int'(frac_y_incr));
            exp_rs = 1;
        end
        tick();
        chk("render_start", line_render_start, exp_rs);
        chk("line_idx", line_idx, m_sy >> 7);
        chk("scanline", scanline, (m_yprev >= 512) ? 511 : (m_y % 512));
    endtask

    task automatic step_pixel();
        int il, x;
        il = int'(interlaced);
        x = m_xc >> 1;
        display_next_pixel = 1'b1;
        tick();
        display_next_pixel = 1'b0;
        if (x >= int'(active_hstart) && x < int'(active_hstop) && (m_sx >> 7) < 640)
            m_sx = m_sx + ((il != 0) ? int'(frac_x_incr) / 2 : int'(frac_x_incr));
        m_xc = (m_xc + ((il != 0) ? 1 : 2)) % 2048;
        if (sprite_lb_erase_start === 1'b1) erase_seen++;
        chk("lb_rdidx", lb_rdidx, m_sx >> 7);
        chk("erase_start", sprite_lb_erase_start, m_xc == 639 * 2 + il);
    endtask

    task automatic check_display(input string tag);
        bit vact;
        vact = m_yprev >= int'(active_vstart) && m_yprev < int'(active_vstop)
            && (m_sy >> 7) < 480;
        tick();
        tick();
        chk(tag, display_data, vact ? ref_pix(layer_enable, sprites_enabled,
            layer_lb_rddata, sprite_lb_rddata) : border_color);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 60; i++) begin
            mx_en = NL'($urandom);
            mx_se = 1'($urandom);
            mx_ld = {rnd_pix(), rnd_pix(), rnd_pix(), rnd_pix()};
            mx_sd = {3'($urandom), rnd_pix()};
            #1;
            chk("mux_solo", mx_pix, ref_pix(mx_en, mx_se, mx_ld, mx_sd));
        end

        layer_lb_rddata = {8'h00, 8'h33, 8'h22, 8'h11};
        sprite_lb_rddata = {3'd4, 8'h55};
        tick();
        chk("comp_z4", display_data, 8'h55);
        sprite_lb_rddata = {3'd3, 8'h55};
        tick();
        chk("comp_z3", display_data, 8'h33);
        sprite_lb_rddata = {3'd0, 8'h55};
        tick();
        chk("comp_z0", display_data, 8'h33);
        sprite_lb_rddata = {3'd5, 8'h55};
        tick();
        chk("comp_z5_top", display_data, 8'h55);
        sprite_lb_rddata = {3'd6, 8'h55};
        tick();
        chk("comp_z6_hidden", display_data, 8'h33);
        layer_enable = 4'b1011;
        tick();
        chk("comp_l2_off", display_data, 8'h22);
        layer_enable = 4'b1111;
        sprites_enabled = 1'b0;
        sprite_lb_rddata = {3'd4, 8'h55};
        tick();
        chk("comp_spr_off", display_data, 8'h33);
        sprites_enabled = 1'b1;

        for (int i = 0; i < 20; i++) begin
            layer_enable = NL'($urandom);
            sprites_enabled = 1'($urandom);
            layer_lb_rddata = {rnd_pix(), rnd_pix(), rnd_pix(), rnd_pix()};
            sprite_lb_rddata = {3'($urandom), rnd_pix()};
            tick();
            chk("comp_rand", display_data,
                ref_pix(layer_enable, sprites_enabled, layer_lb_rddata, sprite_lb_rddata));
        end
        layer_enable = '1;
        sprites_enabled = 1'b1;

        layer_lb_rddata = '0;
        sprite_lb_rddata = {3'd2, 8'h00};
        tick();
        chk("all_transparent", display_data, 8'h00);
        active_hstart = 10'd100;
        tick();
        chk("border_lat1", display_data, 8'h00);
        tick();
        chk("border_lat2", display_data, 8'h1F);
        active_hstart = '0;
        tick();
        tick();

        do_line();
        for (int i = 0; i < 5; i++) step_pixel();
        do_line();
        frac_x_incr = 8'($urandom_range(1, 255));
        for (int i = 0; i < 12; i++) step_pixel();

        tick();
        tick();
        step_pixel();
        chk("valid_d1", display_valid, 0);
        tick();
        chk("valid_d2", display_valid, 1);
        tick();
        chk("valid_d3", display_valid, 0);

        do_line();
        interlaced = 1'b1;
        frac_x_incr = 8'd200;
        for (int i = 0; i < 6; i++) step_pixel();
        interlaced = 1'b0;

        do_line();
        frac_x_incr = 8'd128;
        erase_seen = 0;
        for (int i = 0; i < 700; i++) step_pixel();
        chk("erase_count", erase_seen, 1);
        chk("rdidx_hold", lb_rdidx, 640);

        interlaced = 1'b1;
        irqline = 9'd21;
        frac_y_incr = 8'd100;
        display_current_field = 1'b0;
        display_next_frame = 1'b1;
        tick();
        display_next_frame = 1'b0;
        m_y = 1;
        m_field = 1;
        m_started = 0;
        chk("field_after_frame", current_field, 1);
        chk("scanline_frame", scanline, (m_yprev >= 512) ? 511 : m_y);
        irq_seen = 0;
        for (int i = 0; i < 14; i++) do_line();
        chk("irq_count", irq_seen, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        interlaced = 1'b0;
        irqline = '0;
        active_vstop = 9'd500;
        frac_y_incr = 8'd192;
        layer_lb_rddata = {8'h00, 8'h44, 8'h00, 8'h11};
        sprite_lb_rddata = {3'd1, 8'h66};
        display_current_field = 1'b1;
        display_next_frame = 1'b1;
        tick();
        display_next_frame = 1'b0;
        m_y = 0;
        m_field = 0;
        chk("field_noninterlaced", current_field, 0);
        for (int k = 1; k <= 525; k++) begin
            do_line();
            if (k == 300) check_display("disp_in_rows");
            if (k == 330) check_display("disp_past_rows");
        end

        display_current_field = 1'b0;
        display_next_frame = 1'b1;
        display_next_line = 1'b1;
        tick();
        display_next_frame = 1'b0;
        display_next_line = 1'b0;
        chk("combo_irq", line_irq, (m_y == int'(irqline)) ? 1 : 0);
        m_y = 0;
        m_field = 1;
        m_started = 0;
        m_xc = 0;
        m_sx = 0;
        chk("combo_field", current_field, 1);
        chk("combo_scanline", scanline, (m_yprev >= 512) ? 511 : m_y);
        tick();
        chk("combo_no_render", line_render_start, 0);
        do_line();

        for (int i = 0; i < 3; i++) step_pixel();
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
